// File: rtl/addsub_pkg.sv
// Shared definitions for the sliced adder-subtractor: opcodes, FSM states and
// the slice-count helper.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit ripple adder. b arrives already inverted for subtract;
// c_msb is the carry into the top bit, used for signed overflow on the last slice.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] carry;

  // ripple chain across the slice
  always_comb begin
    carry    = {(SLICE+1){1'b0}};
    sum      = {SLICE{1'b0}};
    carry[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout  = carry[SLICE];
    c_msb = carry[SLICE-1];
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder-subtractor: one SLICE-bit chunk per clock, valid/ready on both sides.
// Optional signed saturation of overflowing results when ADDSUB_SAT_EN is defined.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             v,
  output logic             z
);

  if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("addsub_seq: WIDTH must be >= 2 and SLICE >= 1 must divide WIDTH");
  end

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_c_msb;
  logic [WIDTH-1:0] run_sum;
  logic [WIDTH-1:0] final_sum;
  logic             ovf;

  // pick the operand chunk addressed by the slice counter
  always_comb begin
    slice_a = {SLICE{1'b0}};
    slice_b = {SLICE{1'b0}};
    for (int k = 0; k < NSLICE; k++) begin
      if (int'(idx_q) == k) begin
        slice_a = a_q[k*SLICE +: SLICE];
        slice_b = b_q[k*SLICE +: SLICE];
      end else begin
        slice_a = slice_a;
        slice_b = slice_b;
      end
    end
  end

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c_msb(slice_c_msb)
  );

  // merge the fresh chunk into the running sum and form the final result
  always_comb begin
    run_sum = sum_q;
    for (int k = 0; k < NSLICE; k++) begin
      if (int'(idx_q) == k) begin
        run_sum[k*SLICE +: SLICE] = slice_sum;
      end else begin
        run_sum = run_sum;
      end
    end
    ovf = slice_c_msb ^ slice_cout;
`ifdef ADDSUB_SAT_EN
    if (ovf) begin
      final_sum = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_sum = run_sum;
    end
`else
    final_sum = run_sum;
`endif
  end

  // next-state and datapath updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b ^ {WIDTH{op}};
          carry_d = (op == OP_SUB) ? 1'b1 : cin;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = run_sum;
        carry_d = slice_cout;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          idx_d   = {IDX_W{1'b0}};
          sum_d   = final_sum;
          cout_d  = slice_cout;
          v_d     = ovf;
          z_d     = (final_sum == {WIDTH{1'b0}});
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign v         = v_q;
  assign z         = z_q;

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle signed/unsigned adder-subtractor. Successor to the fixed 4-bit ripple add/sub unit.
- Processes a WIDTH-bit operand pair in SLICE-bit chunks, one chunk per clock, carrying between chunks through a register.
- Uses valid/ready handshakes on input and output so it can sit between the operand register file and the ALU result mux.
- Flags: carry-out, signed overflow, zero.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be at least 2.
- SLICE, 4: bits processed per cycle. Must be at least 1 and must divide WIDTH. Any other value is an elaboration error.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  1  0 = add, 1 = subtract (A - B).
- cin  in  1  carry-in; used for add only.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- v  out  1  signed overflow.
- z  out  1  result equals zero.

Behaviour:
- Reset and handshake:
  - Reset is synchronous and active-high on clk; clock port is clk, reset port is rst.
  - Reset values: state IDLE, out_valid=0, sum=0, cout=0, v=0, z=0, internal carry and slice index = 0.
  - in_ready = (state==IDLE), decoded combinationally from state. It is 1 in the cycle after reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on in_valid&&in_ready at an edge. That edge registers a, b XOR {WIDTH{op}}, and carry0 = op ? 1 : cin.
  - RUN: each edge adds slice i (bits i*SLICE .. i*SLICE+SLICE-1), writes the slice into sum, and registers the carry. After slice NSLICE-1 (NSLICE = WIDTH/SLICE), the state goes to DONE and cout, v and z are set.
  - DONE: holds sum and flags with out_valid=1. On out_valid&&out_ready the state returns to IDLE.
  - There is no IDLE bypass: a new operand pair is accepted no earlier than the cycle after the result handoff.
- Latency: out_valid rises exactly NSLICE cycles after the accept edge. With SLICE==WIDTH this is 1 cycle.
- Arithmetic:
  - v = carry into the MSB XOR carry out of the MSB.
  - z = (sum == 0), evaluated on the final sum.
  - cout is not inverted for subtract.
  - Add wraps modulo 2^WIDTH. For subtract, cin is ignored.
- Output stability: while out_valid=1 and out_ready=0, sum, cout, v and z hold stable. After handoff they keep their last values while out_valid=0.
- Boundary conditions:
  - in_valid in RUN or DONE is ignored, and operand inputs are not sampled.
  - in_valid asserted in the same cycle as rst is ignored.
  - rst in RUN or DONE aborts the operation. The next cycle is IDLE with all outputs at reset values, and no partial result is delivered.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: when v=1, sum is clamped on the DONE transition. If a[WIDTH-1]=0, sum = 0 followed by all ones (signed max). Otherwise sum = 1 followed by all zeros (signed min). v still reports 1, cout reports the raw carry, and z uses the clamped sum.
- Undefined: results wrap and no clamp logic is present.

Decomposition:
- Shared package addsub_pkg contains:
  - OP_ADD=1'b0 and OP_SUB=1'b1.
  - The state enum (IDLE/RUN/DONE).
  - An NSLICE helper function.
- Sub-module addsub_slice: a combinational SLICE-bit ripple adder.
  - Inputs: a, b (pre-inverted), cin.
  - Outputs: sum, cout, and c_msb (carry into its top bit), used for v on the last slice.
- The top level holds the FSM, the slice counter, the operand registers and the flags.

Test Plan:
- All tests use WIDTH=16, SLICE=4.
- Add overflow: a=0x7FFF, b=0x0001, op=0, cin=0 -> after 4 cycles, out_valid=1, sum=0x8000, cout=0, v=1, z=0. With ADDSUB_SAT_EN: sum=0x7FFF.
- Subtract with borrow: a=0x0005, b=0x0007, op=1, cin=0 -> sum=0xFFFE, cout=0, v=0, z=0. Repeat with cin=1: identical result.
- Zero and negative overflow:
  - a=0x1234, b=0x1234, op=1 -> sum=0x0000, cout=1, z=1.
  - a=0x8000, b=0x0001, op=1 -> sum=0x7FFF, cout=1, v=1. With ADDSUB_SAT_EN: sum=0x8000.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable and in_ready=0. Raise out_ready -> IDLE next cycle, and a back-to-back in_valid is accepted one cycle after handoff.
- Reset mid-RUN: assert rst on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0. No result appears afterwards.
- Add carry chain: a=0xFFFF, b=0x0000, op=0, cin=1 -> sum=0x0000, cout=1, v=0, z=1. This exercises the carry through all 4 slices.
